// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes and pipeline control bit positions.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_DIV  = 4'b1101;
  localparam logic [3:0] ALU_REM  = 4'b1110;

  // Bit positions inside the 4-bit control field {reg_write, mem_read, mem_write, branch}
  localparam int CTL_RW = 3;
  localparam int CTL_MR = 2;
  localparam int CTL_MW = 1;
  localparam int CTL_BR = 0;

endpackage

// File: rtl/id_ex_pipe_if.sv
// Bundle of decode-side, forwarding and execute-side signals of the ID/EX stage.
interface id_ex_pipe_if #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic [3:0]        in_alu_ctrl;
  logic              in_use_imm;
  logic              in_use_pc;
  logic [3:0]        in_ctl;

  logic              exm_wr;
  logic [REG_AW-1:0] exm_rd;
  logic [XLEN-1:0]   exm_res;
  logic              mwb_wr;
  logic [REG_AW-1:0] mwb_rd;
  logic [XLEN-1:0]   mwb_res;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_store_data;
  logic [REG_AW-1:0] out_rd;
  logic [3:0]        out_ctl;

  modport master (
    output flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_ctrl, in_use_imm, in_use_pc, in_ctl,
           exm_wr, exm_rd, exm_res, mwb_wr, mwb_rd, mwb_res, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_pc,
           out_store_data, out_rd, out_ctl
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_alu_ctrl, in_use_imm, in_use_pc, in_ctl,
           exm_wr, exm_rd, exm_res, mwb_wr, mwb_rd, mwb_res, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_pc,
           out_store_data, out_rd, out_ctl
  );

endinterface

// File: rtl/id_ex_pipe_fwd_mux.sv
// Per-operand forwarding selector: EX/MEM result beats MEM/WB, x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   stored,
  input  logic              exm_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_res,
  input  logic              mwb_wr,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_res,
  output logic [XLEN-1:0]   fwd
);

  logic rs_nz;
  logic exm_hit;
  logic mwb_hit;

  assign rs_nz   = (rs != '0);
  assign exm_hit = rs_nz && exm_wr && (exm_rd == rs);
  assign mwb_hit = rs_nz && mwb_wr && (mwb_rd == rs);

  always_comb begin
    if (exm_hit)      fwd = exm_res;
    else if (mwb_hit) fwd = mwb_res;
    else              fwd = stored;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: 2-entry skid buffer with registered in_ready, flush,
// and operand forwarding on the head entry feeding the ALU.
module id_ex_pipe #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_pipe_if.slave bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_ctrl;
    logic              use_imm;
    logic              use_pc;
    logic [3:0]        ctl;
  } entry_t;

  entry_t     in_entry, head, skid;
  logic       h_valid, s_valid, in_ready_q;
  logic       h_valid_n, s_valid_n;
  logic       load_h_in, load_h_skid, load_s;
  logic       accept, consume;
  logic [1:0] state;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign in_entry = '{pc: bus.in_pc, rs1_data: bus.in_rs1_data, rs2_data: bus.in_rs2_data,
                      imm: bus.in_imm, rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                      alu_ctrl: bus.in_alu_ctrl, use_imm: bus.in_use_imm,
                      use_pc: bus.in_use_pc, ctl: bus.in_ctl};

  // An instruction offered during a flush cycle is dropped, even if in_ready is high
  assign accept  = bus.in_valid && in_ready_q && !bus.flush;
  assign consume = h_valid && bus.out_ready;

  always_comb begin
    if (s_valid)      state = TWO;
    else if (h_valid) state = ONE;
    else              state = EMPTY;
  end

  always_comb begin
    h_valid_n   = h_valid;
    s_valid_n   = s_valid;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    if (bus.flush) begin
      h_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          h_valid_n = 1'b1;
          load_h_in = 1'b1;
        end
        ONE: begin
          if (accept && consume) begin
            load_h_in = 1'b1;
          end else if (accept) begin
            s_valid_n = 1'b1;
            load_s    = 1'b1;
          end else if (consume) begin
            h_valid_n = 1'b0;
          end
        end
        TWO: if (consume) begin
          s_valid_n   = 1'b0;
          load_h_skid = 1'b1;
        end
        default: begin
          h_valid_n = 1'b0;
          s_valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      head       <= '0;
      skid       <= '0;
    end else begin
      h_valid    <= h_valid_n;
      s_valid    <= s_valid_n;
      in_ready_q <= !(h_valid_n && s_valid_n);
      if (load_h_in)        head <= in_entry;
      else if (load_h_skid) head <= skid;
      if (load_s)           skid <= in_entry;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs(head.rs1), .stored(head.rs1_data),
    .exm_wr(bus.exm_wr), .exm_rd(bus.exm_rd), .exm_res(bus.exm_res),
    .mwb_wr(bus.mwb_wr), .mwb_rd(bus.mwb_rd), .mwb_res(bus.mwb_res),
    .fwd(rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs(head.rs2), .stored(head.rs2_data),
    .exm_wr(bus.exm_wr), .exm_rd(bus.exm_rd), .exm_res(bus.exm_res),
    .mwb_wr(bus.mwb_wr), .mwb_rd(bus.mwb_rd), .mwb_res(bus.mwb_res),
    .fwd(rs2_fwd)
  );

  // Bubbles carry zero control bits so nothing downstream writes state
  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = h_valid;
  assign bus.alu_a          = head.use_pc  ? head.pc  : rs1_fwd;
  assign bus.alu_b          = head.use_imm ? head.imm : rs2_fwd;
  assign bus.alu_ctrl       = head.alu_ctrl;
  assign bus.out_pc         = head.pc;
  assign bus.out_store_data = rs2_fwd;
  assign bus.out_rd         = head.rd;
  assign bus.out_ctl        = h_valid ? head.ctl : 4'b0000;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: scoreboard of accepted instructions plus directed checks.
module tb_id_ex_pipe;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_pipe_if bus ();
  id_ex_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_ctrl, ctl;
    logic        use_imm, use_pc;
  } instr_t;

  instr_t sb[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference forwarding rule applied to the head entry with the current bypass inputs
  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (rs != 5'd0 && bus.exm_wr && bus.exm_rd == rs) return bus.exm_res;
    if (rs != 5'd0 && bus.mwb_wr && bus.mwb_rd == rs) return bus.mwb_res;
    return stored;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, rs1d, rs2d, imm,
                                input logic [4:0] rs1, rs2, rd, input logic [3:0] alu,
                                input logic use_imm, use_pc, input logic [3:0] ctl);
    instr_t i;
    i.pc = pc; i.rs1_data = rs1d; i.rs2_data = rs2d; i.imm = imm;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.alu_ctrl = alu;
    i.use_imm = use_imm; i.use_pc = use_pc; i.ctl = ctl;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    return mk($urandom, $urandom, $urandom, $urandom,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
  endfunction

  task automatic applyStimulus(input instr_t i);
    bus.in_pc = i.pc; bus.in_rs1_data = i.rs1_data; bus.in_rs2_data = i.rs2_data;
    bus.in_imm = i.imm; bus.in_rs1 = i.rs1; bus.in_rs2 = i.rs2; bus.in_rd = i.rd;
    bus.in_alu_ctrl = i.alu_ctrl; bus.in_use_imm = i.use_imm; bus.in_use_pc = i.use_pc;
    bus.in_ctl = i.ctl; bus.in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(bus.out_valid), 32'd0);
    step();
  endtask

  always @(negedge rst_n) sb.delete();

  // Pop and compare on every consume, push on every accept; flush empties the scoreboard
  always @(negedge clk) begin
    instr_t e;
    if (rst_n) begin
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (!bus.out_valid) checkOutput("bubble_ctl", 32'(bus.out_ctl), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            pops++;
            checkOutput("sb_alu_a", bus.alu_a, e.use_pc ? e.pc : model_fwd(e.rs1, e.rs1_data));
            checkOutput("sb_alu_b", bus.alu_b, e.use_imm ? e.imm : model_fwd(e.rs2, e.rs2_data));
            checkOutput("sb_store", bus.out_store_data, model_fwd(e.rs2, e.rs2_data));
            checkOutput("sb_alu_ctrl", 32'(bus.alu_ctrl), 32'(e.alu_ctrl));
            checkOutput("sb_pc", bus.out_pc, e.pc);
            checkOutput("sb_rd", 32'(bus.out_rd), 32'(e.rd));
            checkOutput("sb_ctl", 32'(bus.out_ctl), 32'(e.ctl));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(mk(bus.in_pc, bus.in_rs1_data, bus.in_rs2_data, bus.in_imm,
                          bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_alu_ctrl,
                          bus.in_use_imm, bus.in_use_pc, bus.in_ctl));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int pops0;
    int sent;
    logic acc;

    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_pc = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_alu_ctrl = '0;
    bus.in_use_imm = 1'b0; bus.in_use_pc = 1'b0; bus.in_ctl = '0;
    bus.exm_wr = 1'b0; bus.exm_rd = '0; bus.exm_res = '0;
    bus.mwb_wr = 1'b0; bus.mwb_rd = '0; bus.mwb_res = '0;

    #12;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_ctl", 32'(bus.out_ctl), 32'd0);
    checkOutput("rst_alu_a", bus.alu_a, 32'd0);
    checkOutput("rst_alu_b", bus.alu_b, 32'd0);
    checkOutput("rst_out_pc", bus.out_pc, 32'd0);
    step();
    rst_n = 1'b1;

    // Basic single instruction with one-cycle latency
    step();
    applyStimulus(mk(32'h40, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 1'b0, 4'b1000));
    bus.out_ready = 1'b1;
    wait_accept("t1_accept");
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_alu_a", bus.alu_a, 32'd5);
    checkOutput("t1_alu_b", bus.alu_b, 32'd7);
    checkOutput("t1_alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
    step();

    // Backpressure: third instruction must wait while both entries are full
    bus.out_ready = 1'b0;
    applyStimulus(mk(32'h101, 32'h11, 32'h12, 32'h0, 5'd6, 5'd7, 5'd1, ALU_ADD, 1'b0, 1'b0, 4'b1000));
    wait_accept("bp_acc1");
    applyStimulus(mk(32'h102, 32'h21, 32'h22, 32'h0, 5'd6, 5'd7, 5'd2, ALU_XOR, 1'b0, 1'b0, 4'b1000));
    wait_accept("bp_acc2");
    applyStimulus(mk(32'h103, 32'h31, 32'h32, 32'h0, 5'd6, 5'd7, 5'd3, ALU_SUB, 1'b0, 1'b0, 4'b1000));
    @(negedge clk);
    checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_head_hold", bus.out_pc, 32'h101);
    @(negedge clk);
    checkOutput("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    pops0 = pops;
    wait_accept("bp_acc3");
    bus.in_valid = 1'b0;
    wait_drain("bp_drain");
    checkOutput("bp_pop_count", 32'(pops - pops0), 32'd3);
    checkOutput("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Forwarding priority on a held head entry
    bus.out_ready = 1'b0;
    applyStimulus(mk(32'h200, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd6, ALU_SUB, 1'b0, 1'b0, 4'b1000));
    wait_accept("fw_accept");
    bus.in_valid = 1'b0;
    bus.exm_wr = 1'b1; bus.exm_rd = 5'd3; bus.exm_res = 32'hAAAA0000;
    bus.mwb_wr = 1'b1; bus.mwb_rd = 5'd3; bus.mwb_res = 32'h1234;
    @(negedge clk);
    checkOutput("fw_exm_wins", bus.alu_a, 32'hAAAA0000);
    step();
    bus.exm_wr = 1'b0;
    @(negedge clk);
    checkOutput("fw_mwb", bus.alu_a, 32'h1234);
    step();
    bus.mwb_wr = 1'b0;
    @(negedge clk);
    checkOutput("fw_none", bus.alu_a, 32'h11);
    step();
    bus.out_ready = 1'b1;
    wait_drain("fw_drain");

    // x0 is never forwarded
    bus.out_ready = 1'b0;
    applyStimulus(mk(32'h300, 32'h77, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, ALU_OR, 1'b0, 1'b0, 4'b1000));
    wait_accept("x0_accept");
    bus.in_valid = 1'b0;
    bus.exm_wr = 1'b1; bus.exm_rd = 5'd0; bus.exm_res = 32'hFFFFFFFF;
    bus.mwb_wr = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_res = 32'hDEAD;
    @(negedge clk);
    checkOutput("x0_alu_b", bus.alu_b, 32'd0);
    checkOutput("x0_store", bus.out_store_data, 32'd0);
    checkOutput("x0_alu_a", bus.alu_a, 32'h77);
    step();
    bus.out_ready = 1'b1;
    wait_drain("x0_drain");
    bus.exm_wr = 1'b0; bus.mwb_wr = 1'b0;

    // Flush while full, with an instruction offered in the flush cycle
    bus.out_ready = 1'b0;
    applyStimulus(mk(32'h401, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_AND, 1'b0, 1'b0, 4'b1000));
    wait_accept("fl_acc1");
    applyStimulus(mk(32'h402, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_AND, 1'b0, 1'b0, 4'b1000));
    wait_accept("fl_acc2");
    applyStimulus(mk(32'hBAD, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_AND, 1'b0, 1'b0, 4'b1111));
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("fl_two_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fl_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_out_ctl", 32'(bus.out_ctl), 32'd0);
    checkOutput("fl_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Flush with one entry held and an acceptable offer: the offer is dropped
    applyStimulus(mk(32'h501, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_OR, 1'b0, 1'b0, 4'b1000));
    wait_accept("fl1_acc");
    applyStimulus(mk(32'hBAD2, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, ALU_OR, 1'b0, 1'b0, 4'b1111));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fl1_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl1_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    @(negedge clk);
    checkOutput("fl1_no_ghost", 32'(bus.out_valid), 32'd0);
    step();

    // Operand select with forwarded store data, then async reset mid-stream
    bus.exm_wr = 1'b1; bus.exm_rd = 5'd5; bus.exm_res = 32'h55;
    applyStimulus(mk(32'h100, 32'h9999, 32'h9, 32'hFFFFFFFC, 5'd2, 5'd5, 5'd8, ALU_ADD, 1'b1, 1'b1, 4'b0010));
    wait_accept("os_accept");
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("os_alu_a", bus.alu_a, 32'h100);
    checkOutput("os_alu_b", bus.alu_b, 32'hFFFFFFFC);
    checkOutput("os_store", bus.out_store_data, 32'h55);
    checkOutput("os_out_ctl", 32'(bus.out_ctl), 32'h2);
    step();
    applyStimulus(mk(32'h104, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd9, ALU_SLT, 1'b0, 1'b0, 4'b1000));
    wait_accept("os_acc2");
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_async_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_async_out_ctl", 32'(bus.out_ctl), 32'd0);
    step();
    rst_n = 1'b1;
    bus.exm_wr = 1'b0;
    step();

    // Random traffic with random backpressure and bypass activity
    sent = 0;
    applyStimulus(rand_instr());
    for (int cyc = 0; cyc < 600 && sent < 40; cyc++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (acc || !bus.in_valid) begin
        if ($urandom_range(0, 3) != 0) applyStimulus(rand_instr());
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.exm_wr = 1'($urandom_range(0, 1)); bus.exm_rd = 5'($urandom_range(0, 3)); bus.exm_res = $urandom;
      bus.mwb_wr = 1'($urandom_range(0, 1)); bus.mwb_rd = 5'($urandom_range(0, 3)); bus.mwb_res = $urandom;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("rnd_drain");
    checkOutput("rnd_sent", 32'(sent), 32'd40);
    checkOutput("rnd_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline stage sitting directly upstream of the ALU.
- Registers decoded instructions, resolves operand forwarding from the EX/MEM and MEM/WB stages, and drives the ALU's a, b and alu_ctrl inputs.
- Decouples decode from execute with a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal. Supports flush on branch/jump redirect.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries (redirect)
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept; registered
- in_pc  in  XLEN  instruction PC
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2, in_rd  in  REG_AW  register addresses
- in_alu_ctrl  in  4  ALU opcode, same encoding as ALU
- in_use_imm  in  1  b operand = imm
- in_use_pc  in  1  a operand = pc
- in_ctl  in  4  {reg_write, mem_read, mem_write, branch}
- exm_wr, mwb_wr  in  1  EX/MEM and MEM/WB write enables
- exm_rd, mwb_rd  in  REG_AW  destination addresses
- exm_res, mwb_res  in  XLEN  forwardable results
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- alu_a, alu_b  out  XLEN  ALU operands
- alu_ctrl  out  4  ALU opcode
- out_pc, out_store_data  out  XLEN  PC; forwarded rs2 for stores
- out_rd  out  REG_AW  destination address
- out_ctl  out  4  control bits

Behaviour:
- Storage: two entries, head (H) and skid (S), each with a valid bit. Payload is all in_* fields.
- Reset (rst_n low, async): H.valid=0, S.valid=0, in_ready=1, out_valid=0. Payload registers reset to 0, so all data outputs read 0.
- Handshake: accept when in_valid && in_ready; consume when out_valid && out_ready. out_valid = H.valid. Each transfer happens in exactly one cycle.
- Latency: an accepted instruction appears on outputs the next cycle when H is empty or consumed that cycle; otherwise it lands in S.
- State transitions per clock (states EMPTY, ONE, TWO):
  - EMPTY + accept -> ONE.
  - ONE + accept, no consume -> TWO (new entry into S).
  - ONE + accept + consume -> ONE (new entry into H).
  - ONE + consume -> EMPTY.
  - TWO + consume -> ONE (S moves to H).
  - No accept is possible in TWO.
- in_ready registered: next in_ready = (next state != TWO).
- flush: synchronous, highest priority. Next state is EMPTY and in_ready=1 next cycle. An instruction offered in the flush cycle is dropped even if in_valid && in_ready.
- Forwarding (combinational, head entry only, re-evaluated every cycle while held). For each of rs1/rs2:
  - if exm_wr && exm_rd==rs && rs!=0, use exm_res;
  - else if mwb_wr && mwb_rd==rs && rs!=0, use mwb_res;
  - else use stored reg data.
  - EX/MEM beats MEM/WB when both match.
  - Register x0 is never forwarded and always reads the stored value.
- Operand select: alu_a = use_pc ? pc : fwd_rs1; alu_b = use_imm ? imm : fwd_rs2; out_store_data = fwd_rs2 regardless of use_imm.
- When out_valid=0, out_ctl is forced to 0 so no bubble writes state. Data outputs are don't-care.
- Output changes are permitted only on consume or flush, except forwarded operand values.
- Async reset mid-operation clears both entries immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_SLTU=4'b1100, ALU_XOR=4'b0011, ALU_SLL=4'b1000, ALU_SRL=4'b1001, ALU_SRA=4'b1010, ALU_MUL=4'b1011, ALU_DIV=4'b1101, ALU_REM=4'b1110);
  - control bit indices CTL_RW=3, CTL_MR=2, CTL_MW=1, CTL_BR=0;
  - XLEN/REG_AW defaults.
- One sub-module, fwd_mux: a per-operand forwarding selector instantiated twice for rs1 and rs2.

Test Plan:
- Reset then in_valid with rs1_data=5, rs2_data=7, alu_ctrl=ALU_ADD, no forwarding -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_ctrl=4'b0010.
- Backpressure: out_ready=0, push three instructions back to back -> in_ready falls to 0 after the second accept; third held by decode. On release, outputs in order 1,2,3; no loss or duplication.
- Forwarding priority: head rs1=3, exm_wr=1/exm_rd=3/exm_res=0xAAAA0000, mwb_wr=1/mwb_rd=3/mwb_res=0x1234 -> alu_a=0xAAAA0000. Drop exm_wr -> alu_a=0x1234.
- x0 guard: rs2=0, exm_wr=1, exm_rd=0, exm_res=0xFFFFFFFF, stored rs2_data=0 -> alu_b=0 and out_store_data=0.
- Flush in TWO state with in_valid=1 -> next cycle out_valid=0, out_ctl=0, in_ready=1; the offered instruction never appears.
- Operand select: use_pc=1, pc=0x100, use_imm=1, imm=0xFFFFFFFC, rs2 forwarded 0x55 -> alu_a=0x100, alu_b=0xFFFFFFFC, out_store_data=0x55. Assert rst_n low mid-stream -> out_valid=0 immediately, without waiting for clk.
